y86_seq_ctrl: RTL and testbench
===============================

# y86_seq_ctrl

Multi-cycle sequencer for the Y86-64 core. It replaces the free-running single-cycle update with an explicit Fetch/Decode/Execute/Memory/Writeback state machine. The block issues request/acknowledge handshakes to instruction and data memory and produces the write enables for the register file, condition codes and PC. It sits between the fetch/decode/execute/memory units and the architectural state, and owns the processor status code.

## Interface
- `TIMEOUT`, default 16: maximum cycles a memory request waits for acknowledge; 0 disables the timeout.
- `CNT_W`, default 64: width of the performance counters.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begins execution from IDLE.
- `icode` in 4: current instruction code from fetch.
- `instr_valid` in 1: fetch decoded a legal instruction.
- `imem_err` in 1: fetch address error.
- `dmem_err` in 1: data address error, valid with `dmem_ack`.
- `imem_ack` in 1: instruction memory acknowledge.
- `dmem_ack` in 1: data memory acknowledge.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a write.
- `cc_we` out 1: condition-code write strobe.
- `reg_we` out 1: register file write strobe (dstE/dstM).
- `pc_we` out 1: PC update strobe.
- `stat` out 2: SAOK=0, SHLT=1, SADR=2, SINS=3.
- `busy` out 1: not in IDLE or STOP.
- `cycle_cnt` out CNT_W: active-cycle counter.
- `instr_cnt` out CNT_W: retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRBACK, STOP.
- IDLE: waits for `start`, then goes to FETCH. `start` is ignored in every other state.
- FETCH: holds `imem_req` high until `imem_ack`, then goes to DECODE.
- DECODE, checked in this priority order:
  - `imem_err` → STOP, stat=SADR.
  - `!instr_valid` → STOP, stat=SINS.
  - icode=IHALT → STOP, stat=SHLT.
  - otherwise → EXECUTE.
- EXECUTE: `cc_we` pulses for one cycle when icode=IOPQ. Next state is MEMORY for IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ and IPOPQ; WRBACK for all others.
- MEMORY: holds `dmem_req` high until `dmem_ack`. `dmem_we`=1 for IRMMOVQ, ICALL and IPUSHQ, and is stable for the whole request. On ack with `dmem_err` → STOP, stat=SADR; on ack without error → WRBACK.
- WRBACK: `reg_we` and `pc_we` pulse for one cycle, the instruction retires, next state is FETCH.
- Timeout: with TIMEOUT>0, a request unacknowledged for TIMEOUT cycles → STOP, stat=SADR, request dropped. The wait counter clears on each new request.
- STOP is sticky; only `rst_n` leaves it. No strobes and no requests are issued in STOP.
- Ack while no request is pending is ignored.
- An error or halt stops the instruction before its writeback: no `reg_we` and no `pc_we` for the faulting instruction, so the PC still points at it.

## Timing
- Reset (async assert, sync deassert by the surrounding logic): state=IDLE, stat=SAOK, all request and strobe outputs 0, both counters 0.
- Assertion of `rst_n` low mid-operation drops requests and strobes immediately.
- All outputs are registered or decoded from the state register only. They have no combinational path from `*_ack`.
- Zero-wait memory (ack in the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRBACK).
  - Memory instruction: 5 cycles.
- Each acknowledge wait cycle adds one cycle.
- `start` asserted in cycle n gives `imem_req` high in cycle n+1.
- Requests deassert in the cycle after the accepting ack.

## Configuration
- `Y86_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle while `busy`.
  - `instr_cnt` increments on each WRBACK.
  - Both wrap modulo 2^CNT_W and freeze in STOP.
- Not defined: both counters are driven constant 0 and no counter flops are synthesized. Ports remain present.

## Structure
- Shared defines header holds:
  - icode constants (IHALT…IPOPQ).
  - stat codes SAOK/SHLT/SADR/SINS.
  - state encoding constants.
- One sub-module, `y86_perf_cnt`, contains the two counters. It is instantiated only under `Y86_PERF_CNT_EN`.
- The timeout counter stays inline.

## Test plan
- irmovq then halt with zero-wait acks: `imem_req` pulses at cycles 1 and 5 after `start`, stat=SHLT at cycle 7, and `instr_cnt`=1.
- rmmovq with `dmem_ack` delayed 3 cycles: `dmem_req` and `dmem_we` held for 3 cycles; retire at cycle 8 after `start`.
- opq: `cc_we` high for exactly one cycle, in EXECUTE.
- `imem_err`=1 at DECODE: stat=SADR, `pc_we` never asserted, stays in STOP despite `start`.
- TIMEOUT=4 with `dmem_ack` never asserted: `dmem_req` drops after 4 cycles, stat=SADR.
- `rst_n` low during MEMORY: `dmem_req`=0 immediately, stat=SAOK, counters=0, state IDLE.

Source files
------------

// File: rtl/y86_seq_ctrl_pkg.sv
// Shared constants for the Y86-64 multi-cycle sequencer: icodes, status codes,
// sequencer state encoding and memory-class helpers.
package y86_seq_ctrl_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WRBACK  = 3'd5,
    S_STOP    = 3'd6
  } seq_state_t;

  function automatic logic is_mem_op(input logic [3:0] ic);
    case (ic)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: is_mem_op = 1'b1;
      default:                                      is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_write(input logic [3:0] ic);
    case (ic)
      IRMMOVQ, ICALL, IPUSHQ: is_mem_write = 1'b1;
      default:                is_mem_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_seq_ctrl_perf_cnt.sv
// Performance counters for the sequencer: active cycles and retired instructions.
// Wrap modulo 2^CNT_W; the caller gates the enables so they freeze in STOP.
module y86_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [1:0]            inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign inc = {retire, cnt_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (inc[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign cnt_q[gi] = cnt_reg;
  end

  assign cycle_cnt = cnt_q[0];
  assign instr_cnt = cnt_q[1];

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle Fetch/Decode/Execute/Memory/Writeback sequencer for the Y86-64 core.
// Define Y86_PERF_CNT_EN to build the cycle/instruction counters.
module y86_seq_ctrl
  import y86_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_err,
  input  logic             dmem_err,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             cc_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // Wait counter counts 0..TIMEOUT-1 request cycles; width floors at one bit.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  seq_state_t        state_reg;
  logic [3:0]        icode_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_STOP);

  // All strobes and requests are registered so no *_ack reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      icode_reg    <= INOP;
      wait_cnt_reg <= '0;
      stat         <= SAOK;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      cc_we        <= 1'b0;
      reg_we       <= 1'b0;
      pc_we        <= 1'b0;
    end else begin
      cc_we  <= 1'b0;
      reg_we <= 1'b0;
      pc_we  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg    <= S_FETCH;
            imem_req     <= 1'b1;
            wait_cnt_reg <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req  <= 1'b0;
            state_reg <= S_DECODE;
          end else if (timeout_hit) begin
            imem_req  <= 1'b0;
            stat      <= SADR;
            state_reg <= S_STOP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          icode_reg <= icode;
          if (imem_err) begin
            stat      <= SADR;
            state_reg <= S_STOP;
          end else if (!instr_valid) begin
            stat      <= SINS;
            state_reg <= S_STOP;
          end else if (icode == IHALT) begin
            stat      <= SHLT;
            state_reg <= S_STOP;
          end else begin
            cc_we     <= (icode == IOPQ);
            state_reg <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_mem_op(icode_reg)) begin
            dmem_req     <= 1'b1;
            dmem_we      <= is_mem_write(icode_reg);
            wait_cnt_reg <= '0;
            state_reg    <= S_MEMORY;
          end else begin
            reg_we    <= 1'b1;
            pc_we     <= 1'b1;
            state_reg <= S_WRBACK;
          end
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_err) begin
              stat      <= SADR;
              state_reg <= S_STOP;
            end else begin
              reg_we    <= 1'b1;
              pc_we     <= 1'b1;
              state_reg <= S_WRBACK;
            end
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            stat      <= SADR;
            state_reg <= S_STOP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        S_WRBACK: begin
          imem_req     <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= S_FETCH;
        end
        default: begin
          state_reg <= S_STOP;
        end
      endcase
    end
  end

`ifdef Y86_PERF_CNT_EN
  y86_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_en   (busy),
    .retire   (state_reg == S_WRBACK),
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: instruction flows, waits, faults, timeout, reset.
module tb_y86_seq_ctrl;
  import y86_seq_ctrl_pkg::*;

`ifdef Y86_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = INOP;
  logic        instr_valid = 1'b1;
  logic        imem_err = 1'b0;
  logic        dmem_err = 1'b0;
  logic        imem_ack = 1'b1;
  logic        dmem_ack = 1'b1;
  logic        imem_req, dmem_req, dmem_we, cc_we, reg_we, pc_we, busy;
  logic [1:0]  stat;
  logic [63:0] cycle_cnt, instr_cnt;

  int checks = 0;
  int errors = 0;
  logic pc_seen;

  y86_seq_ctrl #(.TIMEOUT(4), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_err(imem_err), .dmem_err(dmem_err),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .cc_we(cc_we), .reg_we(reg_we),
    .pc_we(pc_we), .stat(stat), .busy(busy), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drive start through cycle 0; on return the bench sits in cycle 1.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_stat", 64'(stat), 64'(SAOK));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'({imem_req, dmem_req, cc_we, reg_we, pc_we}), 64'd0);
    check("rst_cnt", cycle_cnt | instr_cnt, 64'd0);

    // irmovq then halt, zero-wait
    icode = IIRMOVQ; imem_ack = 1'b1; dmem_ack = 1'b1;
    kick();
    check("t1_c1_ireq", 64'(imem_req), 64'd1);
    step();
    check("t1_c2_ireq", 64'(imem_req), 64'd0);
    step();
    check("t1_c3_ccwe", 64'(cc_we), 64'd0);
    check("t1_c3_dreq", 64'(dmem_req), 64'd0);
    step();
    check("t1_c4_wb", 64'({reg_we, pc_we}), 64'b11);
    icode = IHALT;
    step();
    check("t1_c5_ireq", 64'(imem_req), 64'd1);
    check("t1_c5_regwe", 64'(reg_we), 64'd0);
    step();
    step();
    check("t1_c7_stat", 64'(stat), 64'(SHLT));
    check("t1_c7_busy", 64'(busy), 64'd0);
    check("t1_c7_icnt", instr_cnt, PERF ? 64'd1 : 64'd0);
    check("t1_c7_ccnt", cycle_cnt, PERF ? 64'd6 : 64'd0);
    step();
    check("t1_stop_wb", 64'({reg_we, pc_we, imem_req}), 64'd0);

    // rmmovq, dmem_ack arrives in third request cycle
    do_reset();
    icode = IRMMOVQ; dmem_ack = 1'b0;
    kick();
    step();
    step();
    step();
    check("t2_c4_dreq", 64'({dmem_req, dmem_we}), 64'b11);
    step();
    check("t2_c5_dreq", 64'({dmem_req, dmem_we}), 64'b11);
    step();
    check("t2_c6_dreq", 64'({dmem_req, dmem_we}), 64'b11);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("t2_c7_dreq", 64'({dmem_req, dmem_we}), 64'b00);
    check("t2_c7_wb", 64'({reg_we, pc_we}), 64'b11);
    step();
    check("t2_c8_icnt", instr_cnt, PERF ? 64'd1 : 64'd0);
    check("t2_c8_ireq", 64'(imem_req), 64'd1);
    check("t2_c8_stat", 64'(stat), 64'(SAOK));

    // opq: cc_we only in EXECUTE
    do_reset();
    icode = IOPQ; dmem_ack = 1'b1;
    kick();
    step();
    check("t3_c2_ccwe", 64'(cc_we), 64'd0);
    step();
    check("t3_c3_ccwe", 64'(cc_we), 64'd1);
    step();
    check("t3_c4_ccwe", 64'(cc_we), 64'd0);
    check("t3_c4_wb", 64'({reg_we, pc_we, dmem_req}), 64'b110);

    // imem_err at DECODE
    do_reset();
    icode = IOPQ; imem_err = 1'b1; pc_seen = 1'b0;
    kick();
    pc_seen |= pc_we;
    step();
    pc_seen |= pc_we;
    step();
    pc_seen |= pc_we;
    check("t4_stat", 64'(stat), 64'(SADR));
    start = 1'b1;
    step();
    pc_seen |= pc_we;
    step();
    pc_seen |= pc_we;
    start = 1'b0;
    imem_err = 1'b0;
    check("t4_sticky_stat", 64'(stat), 64'(SADR));
    check("t4_sticky_req", 64'({imem_req, busy}), 64'd0);
    check("t4_no_pcwe", 64'(pc_seen), 64'd0);

    // illegal instruction
    do_reset();
    instr_valid = 1'b0;
    kick();
    step();
    step();
    instr_valid = 1'b1;
    check("t5_sins", 64'(stat), 64'(SINS));

    // mrmovq with dmem_ack never: timeout after 4 request cycles
    do_reset();
    icode = IMRMOVQ; dmem_ack = 1'b0;
    kick();
    step();
    step();
    step();
    check("t6_c4_dreq", 64'({dmem_req, dmem_we}), 64'b10);
    step();
    step();
    step();
    check("t6_c7_dreq", 64'(dmem_req), 64'd1);
    check("t6_c7_stat", 64'(stat), 64'(SAOK));
    step();
    check("t6_c8_dreq", 64'(dmem_req), 64'd0);
    check("t6_c8_stat", 64'(stat), 64'(SADR));
    check("t6_c8_wb", 64'({reg_we, pc_we}), 64'd0);

    // dmem_err on ack
    do_reset();
    icode = IPOPQ; dmem_ack = 1'b1; dmem_err = 1'b1;
    kick();
    step();
    step();
    step();
    step();
    dmem_err = 1'b0;
    check("t7_derr_stat", 64'(stat), 64'(SADR));
    check("t7_derr_wb", 64'({reg_we, pc_we}), 64'd0);

    // async reset during MEMORY
    do_reset();
    icode = IPUSHQ; dmem_ack = 1'b0;
    kick();
    step();
    step();
    step();
    check("t8_pre_dreq", 64'({dmem_req, dmem_we}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_rst_dreq", 64'(dmem_req), 64'd0);
    check("t8_rst_stat", 64'(stat), 64'(SAOK));
    check("t8_rst_busy", 64'(busy), 64'd0);
    check("t8_rst_cnt", cycle_cnt | instr_cnt, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t8_idle", 64'({imem_req, busy}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
